// File: rtl/writeback_arbiter_if.sv
// Result/issue/register-file bundle for writeback_arbiter; the arbiter takes the slave side.
// A transfer happens on a rising edge where valid & ready; ready depends only on registered state.
interface writeback_arbiter_if #(
    parameter int REG_COUNT  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  rf_write_enable;
    logic [ADDR_WIDTH-1:0] rf_rd;
    logic [DATA_WIDTH-1:0] rf_write_data;
    logic [REG_COUNT-1:0]  busy_mask;

    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  rf_write_enable, rf_rd, rf_write_data, busy_mask
    );

    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output rf_write_enable, rf_rd, rf_write_data, busy_mask
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Buffers ALU/LSU results in 2-entry FIFOs, arbitrates them onto one register-file write port
// and tracks pending destinations. Optional commit counters under macro WB_STATS_EN.
module writeback_arbiter #(
    parameter int REG_COUNT    = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    writeback_arbiter_if.slave bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0] alu_wb_count,
    output logic [31:0] lsu_wb_count
`endif
);
    // Source index 0 is the ALU, 1 is the LSU.
    logic                  w_in_valid [2];
    logic [ADDR_WIDTH-1:0] w_in_rd    [2];
    logic [DATA_WIDTH-1:0] w_in_data  [2];
    logic                  w_ready    [2];
    logic                  w_ne       [2];
    logic                  w_push     [2];
    logic                  w_pop      [2];

    logic [ADDR_WIDTH-1:0] r_q_rd   [2][2];
    logic [DATA_WIDTH-1:0] r_q_data [2][2];
    logic                  r_wptr   [2];
    logic                  r_rptr   [2];
    logic [1:0]            r_cnt    [2];

    logic [3:0]            r_starve;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic [REG_COUNT-1:0]  r_busy;

    logic                  w_alu_win;
    logic                  w_any_pop;
    logic [ADDR_WIDTH-1:0] w_pop_rd;
    logic [DATA_WIDTH-1:0] w_pop_data;
    logic [REG_COUNT-1:0]  w_busy_next;

    always_comb begin
        w_in_valid[0] = bus.alu_valid;
        w_in_rd[0]    = bus.alu_rd;
        w_in_data[0]  = bus.alu_data;
        w_in_valid[1] = bus.lsu_valid;
        w_in_rd[1]    = bus.lsu_rd;
        w_in_data[1]  = bus.lsu_data;
        for (int s = 0; s < 2; s++) begin
            w_ready[s] = (r_cnt[s] != 2'd2);
            w_ne[s]    = (r_cnt[s] != 2'd0);
            w_push[s]  = w_in_valid[s] && w_ready[s];
        end
        // LSU has priority unless the ALU has been passed over STARVE_LIMIT times in a row.
        w_alu_win  = w_ne[0] && (!w_ne[1] || (r_starve == 4'(STARVE_LIMIT)));
        w_pop[0]   = w_alu_win;
        w_pop[1]   = w_ne[1] && !w_alu_win;
        w_any_pop  = w_pop[0] || w_pop[1];
        w_pop_rd   = w_pop[0] ? r_q_rd[0][r_rptr[0]]   : r_q_rd[1][r_rptr[1]];
        w_pop_data = w_pop[0] ? r_q_data[0][r_rptr[0]] : r_q_data[1][r_rptr[1]];
    end

    // A new issue to the same index outranks the commit of the older producer.
    always_comb begin
        w_busy_next = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            w_busy_next[i] = (bus.issue_valid && (bus.issue_rd == ADDR_WIDTH'(i))) ||
                             (r_busy[i] && !(r_we && (r_rd == ADDR_WIDTH'(i))));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                r_wptr[s] <= 1'b0;
                r_rptr[s] <= 1'b0;
                r_cnt[s]  <= 2'd0;
                for (int e = 0; e < 2; e++) begin
                    r_q_rd[s][e]   <= '0;
                    r_q_data[s][e] <= '0;
                end
            end
            r_starve <= 4'd0;
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_data   <= '0;
            r_busy   <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_q_rd[s][r_wptr[s]]   <= w_in_rd[s];
                    r_q_data[s][r_wptr[s]] <= w_in_data[s];
                    r_wptr[s]              <= ~r_wptr[s];
                end
                if (w_pop[s]) begin
                    r_rptr[s] <= ~r_rptr[s];
                end
                r_cnt[s] <= r_cnt[s] + {1'b0, w_push[s]} - {1'b0, w_pop[s]};
            end
            if (w_ne[0] && w_pop[1]) begin
                r_starve <= r_starve + 4'd1;
            end else begin
                r_starve <= 4'd0;
            end
            // rd=0 entries are consumed without a write; rf_rd/rf_write_data keep their value.
            r_we <= w_any_pop && (w_pop_rd != '0);
            if (w_any_pop && (w_pop_rd != '0)) begin
                r_rd   <= w_pop_rd;
                r_data <= w_pop_data;
            end
            r_busy <= w_busy_next;
        end
    end

    assign bus.alu_ready       = w_ready[0];
    assign bus.lsu_ready       = w_ready[1];
    assign bus.rf_write_enable = r_we;
    assign bus.rf_rd           = r_rd;
    assign bus.rf_write_data   = r_data;
    assign bus.busy_mask       = r_busy;

`ifdef WB_STATS_EN
    logic        r_src_alu;
    logic [31:0] r_alu_wb_cnt;
    logic [31:0] r_lsu_wb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_alu    <= 1'b0;
            r_alu_wb_cnt <= 32'd0;
            r_lsu_wb_cnt <= 32'd0;
        end else begin
            if (w_any_pop) begin
                r_src_alu <= w_pop[0];
            end
            if (r_we) begin
                if (r_src_alu) begin
                    r_alu_wb_cnt <= r_alu_wb_cnt + 32'd1;
                end else begin
                    r_lsu_wb_cnt <= r_lsu_wb_cnt + 32'd1;
                end
            end
        end
    end

    assign alu_wb_count = r_alu_wb_cnt;
    assign lsu_wb_count = r_lsu_wb_cnt;
`endif
endmodule
